load_store_unit: RTL

- Sits between the EX/MEM pipeline register and the 64-bit big-endian byte-addressed `DataMemory`.
- Turns pipeline load/store requests of 1/2/4/8 bytes into `DataMemory` read/write strobes; sign- or zero-extends loads.
- Performs read-modify-write for sub-doubleword stores, since `DataMemory` always writes 8 bytes.
- Returns data or a fault to the MEM/WB stage.

---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bundle of the load/store unit.
//   slave  : the load/store unit (accepts requests, produces responses)
//   master : the EX/MEM stage driving requests and the MEM/WB stage sampling responses
// Signals:
//   req_valid/req_ready  handshake, accept on an edge where both are 1
//   req_write            1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 double
//   req_signed           sign-extend loads
//   req_addr             byte address
//   req_wdata            store data, low 8*n bits used
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data (0 for stores and faults)
//   resp_fault           request rejected, memory untouched
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between EX/MEM and a 64-bit big-endian DataMemory that
// always reads and writes 8 bytes starting at Address.
// Sub-doubleword stores are done as read-modify-write.
// Ports:
//   clock, reset_n         clock and asynchronous active-low reset
//   lsu                    pipeline request/response bundle (slave side)
//   Address, WriteData     to DataMemory
//   MemRead, MemWrite      to DataMemory strobes
//   ReadData               from DataMemory
module load_store_unit #(
  parameter int MEM_TOP = 225
) (
  input  logic                 clock,
  input  logic                 reset_n,
  load_store_unit_if.slave     lsu,
  output logic [7:0]           Address,
  output logic [63:0]          WriteData,
  output logic                 MemRead,
  output logic                 MemWrite,
  input  logic [63:0]          ReadData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic [7:0]  addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q, resp_fault_d;
  logic        lat_write_q, lat_write_d;
  logic [1:0]  lat_size_q, lat_size_d;
  logic        lat_signed_q, lat_signed_d;
  logic [63:0] lat_wdata_q, lat_wdata_d;

  // Misaligned, or the 8-byte memory window would run past MEM_TOP.
  function automatic logic req_fault(input logic [7:0] addr, input logic [1:0] size);
    logic [9:0] last;
    logic       mis;
    last = {2'b00, addr} + 10'd7;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr[0];
      2'b10:   mis = |addr[1:0];
      default: mis = |addr[2:0];
    endcase
    return mis || (last > 10'(MEM_TOP));
  endfunction

  // Big-endian: the addressed bytes sit at the top of ReadData.
  function automatic logic [63:0] load_extend(input logic [63:0] rd, input logic [1:0] size,
                                              input logic sgn);
    logic [63:0] r;
    case (size)
      2'b00:   r = sgn ? {{56{rd[63]}}, rd[63:56]} : {56'h0, rd[63:56]};
      2'b01:   r = sgn ? {{48{rd[63]}}, rd[63:48]} : {48'h0, rd[63:48]};
      2'b10:   r = sgn ? {{32{rd[63]}}, rd[63:32]} : {32'h0, rd[63:32]};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Overlay the new store bytes onto the top of the doubleword just read.
  function automatic logic [63:0] store_merge(input logic [63:0] rd, input logic [63:0] wd,
                                              input logic [1:0] size);
    logic [63:0] r;
    case (size)
      2'b00:   r = {wd[7:0],  rd[55:0]};
      2'b01:   r = {wd[15:0], rd[47:0]};
      2'b10:   r = {wd[31:0], rd[31:0]};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 64'h0;
    resp_fault_d = 1'b0;
    lat_write_d  = lat_write_q;
    lat_size_d   = lat_size_q;
    lat_signed_d = lat_signed_q;
    lat_wdata_d  = lat_wdata_q;
    case (state_q)
      IDLE: begin
        if (lsu.req_valid && ready_q) begin
          lat_write_d  = lsu.req_write;
          lat_size_d   = lsu.req_size;
          lat_signed_d = lsu.req_signed;
          lat_wdata_d  = lsu.req_wdata;
          addr_d       = lsu.req_addr;
          if (req_fault(lsu.req_addr, lsu.req_size)) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else if (!lsu.req_write || (lsu.req_size != 2'b11)) begin
            state_d  = READ;
            mem_rd_d = 1'b1;
          end else begin
            state_d  = WRITE;
            wdata_d  = lsu.req_wdata;
            mem_wr_d = 1'b1;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      READ: begin
        if (lat_write_q) begin
          state_d  = WRITE;
          wdata_d  = store_merge(ReadData, lat_wdata_q, lat_size_q);
          mem_wr_d = 1'b1;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_extend(ReadData, lat_size_q, lat_signed_q);
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      addr_q       <= 8'h0;
      wdata_q      <= 64'h0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'h0;
      resp_fault_q <= 1'b0;
      lat_write_q  <= 1'b0;
      lat_size_q   <= 2'b00;
      lat_signed_q <= 1'b0;
      lat_wdata_q  <= 64'h0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      lat_write_q  <= lat_write_d;
      lat_size_q   <= lat_size_d;
      lat_signed_q <= lat_signed_d;
      lat_wdata_q  <= lat_wdata_d;
    end
  end

  assign lsu.req_ready  = ready_q;
  assign lsu.resp_valid = resp_valid_q;
  assign lsu.resp_rdata = resp_rdata_q;
  assign lsu.resp_fault = resp_fault_q;
  assign Address        = addr_q;
  assign WriteData      = wdata_q;
  assign MemRead        = mem_rd_q;
  assign MemWrite       = mem_wr_q;

endmodule
